// File: rtl/fb_pkg.sv
// Shared constants, state encoding and pixel address helper for the framebuffer pixel sink.
package fb_pkg;

  localparam int X_SCREEN_PIXELS = 160;
  localparam int Y_SCREEN_PIXELS = 120;
  localparam int FB_WORDS        = X_SCREEN_PIXELS * Y_SCREEN_PIXELS;
  localparam int ADDR_W          = 15;
  localparam int COLOUR_W        = 3;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_CLEAR = 2'd2
  } fb_state_e;

  // y*160 + x built from shifts so no multiplier is needed.
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [7:0] px, input logic [6:0] py);
    logic [ADDR_W-1:0] w_y;
    w_y = ADDR_W'(py);
    return (w_y << 7) + (w_y << 5) + ADDR_W'(px);
  endfunction

endpackage

// File: rtl/fb_write_fifo.sv
// Small synchronous FIFO holding pending {addr, colour} framebuffer writes.
module fb_write_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_level == LVL_W'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;

  // NOTE: storage has no reset; the level/pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/fb_pixel_sink.sv
// Pixel-plot sink: clips and addresses plots, queues them, and shares the single-port
// framebuffer RAM between scan-out reads, a hardware clear and queued writes.
module fb_pixel_sink
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  x,
  input  logic [6:0]                  y,
  input  logic [COLOUR_W-1:0]         colour,
  input  logic                        plot,
  output logic                        ready,
  input  logic                        clear_req,
  input  logic [COLOUR_W-1:0]         clear_colour,
  output logic                        clear_done,
  input  logic                        scan_req,
  input  logic [ADDR_W-1:0]           scan_addr,
  output logic                        scan_valid,
  output logic [COLOUR_W-1:0]         scan_colour,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [COLOUR_W-1:0]         mem_wdata,
  output logic                        mem_we,
  input  logic [COLOUR_W-1:0]         mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  clipped_count
);

  localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + COLOUR_W;

  fb_state_e           r_state;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [COLOUR_W-1:0] r_clr_colour;
  logic                r_clear_done;
  logic                r_scan_valid;
  logic [7:0]          r_clipped;

  logic                w_accept;
  logic                w_onscreen;
  logic                w_push;
  logic                w_pop;
  logic                w_clear_wr;
  logic                w_fifo_empty;
  logic [LVL_W-1:0]    w_level;
  logic [ENTRY_W-1:0]  w_din;
  logic [ENTRY_W-1:0]  w_head;

  assign ready      = (r_state == S_RUN) && (w_level != LVL_W'(FIFO_DEPTH));
  assign w_accept   = plot && ready;
  assign w_onscreen = (x < 8'(X_SCREEN_PIXELS)) && (y < 7'(Y_SCREEN_PIXELS));
  assign w_push     = w_accept && w_onscreen;
  assign w_din      = {pixel_addr(x, y), colour};

  fb_write_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_level (w_level),
    .o_empty (w_fifo_empty)
  );

  // Port arbiter: scan-out, then clear, then queued writes.
  // NOTE: every signal gets a default before the if-chain so no latch is inferred.
  always_comb begin
    mem_addr   = scan_addr;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    w_pop      = 1'b0;
    w_clear_wr = 1'b0;
    if (scan_req) begin
      mem_we = 1'b0;
    end else if (r_state == S_CLEAR) begin
      mem_we     = 1'b1;
      mem_addr   = r_clr_cnt;
      mem_wdata  = r_clr_colour;
      w_clear_wr = 1'b1;
    end else if (!w_fifo_empty) begin
      mem_we    = 1'b1;
      mem_addr  = w_head[ENTRY_W-1:COLOUR_W];
      mem_wdata = w_head[COLOUR_W-1:0];
      w_pop     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_RUN;
      r_clr_cnt    <= '0;
      r_clr_colour <= '0;
      r_clear_done <= 1'b0;
      r_scan_valid <= 1'b0;
      r_clipped    <= '0;
    end else begin
      r_scan_valid <= scan_req;
      r_clear_done <= 1'b0;
      if (w_accept && !w_onscreen && (r_clipped != 8'hFF))
        r_clipped <= r_clipped + 8'd1;
      case (r_state)
        S_RUN: begin
          if (clear_req) begin
            r_clr_colour <= clear_colour;
            r_state      <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_level == '0) begin
            r_clr_cnt <= '0;
            r_state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (w_clear_wr) begin
            if (r_clr_cnt == ADDR_W'(FB_WORDS - 1)) begin
              r_clear_done <= 1'b1;
              r_clr_cnt    <= '0;
              r_state      <= S_RUN;
            end else begin
              r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
            end
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign clear_done    = r_clear_done;
  assign scan_valid    = r_scan_valid;
  assign scan_colour   = mem_rdata;
  assign fifo_level    = w_level;
  assign clipped_count = r_clipped;

endmodule

// File: tb/tb_fb_pixel_sink.sv
// Directed + randomized bench for fb_pixel_sink against a queue-based reference model.
module tb_fb_pixel_sink;

  logic        clk;
  logic        reset;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        ready;
  logic        clear_req;
  logic [2:0]  clear_colour;
  logic        clear_done;
  logic        scan_req;
  logic [14:0] scan_addr;
  logic        scan_valid;
  logic [2:0]  scan_colour;
  logic [14:0] mem_addr;
  logic [2:0]  mem_wdata;
  logic        mem_we;
  logic [2:0]  mem_rdata;
  logic [2:0]  fifo_level;
  logic [7:0]  clipped_count;

  fb_pixel_sink dut (
    .clk           (clk),
    .reset         (reset),
    .x             (x),
    .y             (y),
    .colour        (colour),
    .plot          (plot),
    .ready         (ready),
    .clear_req     (clear_req),
    .clear_colour  (clear_colour),
    .clear_done    (clear_done),
    .scan_req      (scan_req),
    .scan_addr     (scan_addr),
    .scan_valid    (scan_valid),
    .scan_colour   (scan_colour),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_rdata     (mem_rdata),
    .fifo_level    (fifo_level),
    .clipped_count (clipped_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Framebuffer RAM with one-cycle registered read.
  logic [2:0] ram [19200];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    int addr;
    int col;
  } wr_t;

  int   total = 0;
  int   bad   = 0;
  wr_t  q[$];
  int   model_fb [19200];
  int   mode;
  int   clr_idx;
  int   clr_col;
  int   clip_m;
  bit   exp_done;
  bit   exp_sv;
  int   sv_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic step(input bit p, input int px, input int py, input int pc,
                      input bit sr, input int sa, input bit cr, input int cc);
    int  lvl0;
    int  next_mode;
    bit  exp_ready;
    wr_t w;
    plot = p; x = px[7:0]; y = py[6:0]; colour = pc[2:0];
    scan_req = sr; scan_addr = sa[14:0]; clear_req = cr; clear_colour = cc[2:0];
    #1;
    check("scan_valid", scan_valid, exp_sv);
    if (exp_sv) check("scan_colour", scan_colour, model_fb[sv_addr]);
    check("clear_done", clear_done, exp_done);
    check("clipped_count", clipped_count, clip_m);
    lvl0 = q.size();
    check("fifo_level", fifo_level, lvl0);
    exp_ready = (mode == 0) && (lvl0 < 4);
    check("ready", ready, exp_ready);

    exp_done  = 0;
    exp_sv    = sr;
    sv_addr   = sa;
    next_mode = mode;
    if (sr) begin
      check("we_scan", mem_we, 0);
      check("addr_scan", mem_addr, sa);
    end else if (mode == 2) begin
      check("we_clear", mem_we, 1);
      check("addr_clear", mem_addr, clr_idx);
      check("data_clear", mem_wdata, clr_col);
      model_fb[clr_idx] = clr_col;
      if (clr_idx == 19199) begin
        exp_done  = 1;
        next_mode = 0;
        clr_idx   = 0;
      end else begin
        clr_idx++;
      end
    end else if (lvl0 > 0) begin
      w = q.pop_front();
      check("we_pix", mem_we, 1);
      check("addr_pix", mem_addr, w.addr);
      check("data_pix", mem_wdata, w.col);
      model_fb[w.addr] = w.col;
    end else begin
      check("we_idle", mem_we, 0);
    end
    if (mode == 1 && lvl0 == 0) begin
      next_mode = 2;
      clr_idx   = 0;
    end
    if (mode == 0 && cr) begin
      next_mode = 1;
      clr_col   = cc;
    end
    if (p && exp_ready) begin
      if (px >= 160 || py >= 120) begin
        if (clip_m < 255) clip_m++;
      end else begin
        w.addr = py * 160 + px;
        w.col  = pc;
        q.push_back(w);
      end
    end
    mode = next_mode;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset with scan_req held so the RAM is not touched during the reset cycles.
  task automatic do_reset();
    reset = 1'b1; plot = 1'b0; clear_req = 1'b0; scan_req = 1'b1; scan_addr = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    mode = 0; clr_idx = 0; clip_m = 0; exp_done = 0; exp_sv = 0; sv_addr = 0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 19200; i++) begin
      ram[i]      = 3'd0;
      model_fb[i] = 0;
    end
    clr_col = 0;
    x = '0; y = '0; colour = '0; clear_colour = '0;
    do_reset();

    // Reset state and single-plot latency.
    step(1, 0, 0, 5, 0, 0, 0, 0);
    idle(1);

    // Far corner, then an off-screen plot.
    step(1, 159, 119, 7, 0, 0, 0, 0);
    idle(1);
    step(1, 160, 5, 1, 0, 0, 0, 0);
    idle(1);

    // Fill the FIFO behind scan reads; fifth plot is refused.
    for (int i = 0; i < 5; i++) step(1, 10 + i, 20 + i, i + 1, 1, 0, 0, 0);
    idle(5);

    // Read back the corner pixel.
    step(0, 0, 0, 0, 1, 19199, 0, 0);
    idle(1);

    // Clip counter saturation.
    for (int i = 0; i < 300; i++) step(1, 200, i % 128, 1, 0, 0, 0, 0);
    idle(1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 175), $urandom_range(0, 127),
           $urandom_range(0, 7), ($urandom_range(0, 3) == 0), $urandom_range(0, 19199), 0, 0);
    end
    idle(6);

    // Clear with two writes pending, random scan stalls and refused plots.
    step(1, 3, 4, 6, 1, 5, 0, 0);
    step(1, 150, 100, 2, 1, 6, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    n = 0;
    while (mode != 0 && n < 21000) begin
      step($urandom_range(0, 1), $urandom_range(0, 159), $urandom_range(0, 119),
           $urandom_range(0, 7), ($urandom_range(0, 15) == 0), $urandom_range(0, 19199), 0, 0);
      n++;
    end
    check("clear_finished", mode, 0);
    idle(2);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1, $urandom_range(0, 19199), 0, 0);
    idle(1);

    // Reset mid-clear.
    step(1, 1, 1, 4, 0, 0, 1, 3);
    n = 0;
    while (!(mode == 2 && clr_idx == 100) && n < 400) begin
      idle(1);
      n++;
    end
    check("reached_addr_100", clr_idx, 100);
    do_reset();
    idle(1);
    for (int i = 0; i < 10; i++) step(1, $urandom_range(0, 159), $urandom_range(0, 119),
                                      $urandom_range(0, 7), 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, i * 20, 0, 0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
